// File: rtl/pixel_streamer_if.sv
// Handshake and frame-store write bundle between a pixel source/sink and pixel_streamer.
// The master side loads pixels, requests frames and paces the stream; the slave side is the streamer.
interface pixel_streamer_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 start;
    logic                 out_ready;
    logic                 in_val;
    logic [DATA_BITS-1:0] data_out;
    logic                 out_eol;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  in_val, data_out, out_eol, out_last, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output in_val, data_out, out_eol, out_last, busy, done
    );
endinterface

// File: rtl/pixel_streamer.sv
// Frame store plus raster streamer: loads a WIDTH x HEIGHT frame while idle, then
// replays it one pixel per accepted handshake with end-of-line / end-of-frame flags.
module pixel_streamer #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    pixel_streamer_if.slave bus
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] mem [0:DEPTH-1];
    logic [ADDR_BITS-1:0] idx, col, row;
    logic [ADDR_BITS-1:0] idx_nxt, col_nxt;
    logic [DATA_BITS-1:0] pix_nxt;
    logic                 in_val, busy, done, out_eol, out_last;
    logic [DATA_BITS-1:0] data_out;
    logic                 xfer, at_last, col_wrap, wr_ok;

    assign xfer     = in_val && bus.out_ready;
    assign at_last  = (idx == ADDR_BITS'(DEPTH - 1));
    assign col_wrap = (col == ADDR_BITS'(WIDTH - 1));
    assign idx_nxt  = idx + 1'b1;
    assign col_nxt  = col_wrap ? '0 : col + 1'b1;
    assign pix_nxt  = mem[idx_nxt[IDX_W-1:0]];
    assign wr_ok    = (state == IDLE) && bus.wr_en &&
                      ({1'b0, bus.wr_addr} < (ADDR_BITS + 1)'(DEPTH));

    // Frame store: no reset, contents must be reloaded after rst.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = STREAM;
            STREAM:  if (xfer && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage: the pixel for index idx is registered so data_out is glitch-free and
    // the next pixel is fetched in the same edge that retires the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_val   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_eol  <= 1'b0;
            out_last <= 1'b0;
            data_out <= '0;
            idx      <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && bus.start) begin
                in_val   <= 1'b1;
                busy     <= 1'b1;
                data_out <= mem[0];
                idx      <= '0;
                col      <= '0;
                row      <= '0;
                out_eol  <= (WIDTH == 1);
                out_last <= (DEPTH == 1);
            end else if (state == STREAM && xfer) begin
                if (at_last) begin
                    in_val   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    out_eol  <= 1'b0;
                    out_last <= 1'b0;
                end else begin
                    idx      <= idx_nxt;
                    col      <= col_nxt;
                    row      <= col_wrap ? row + 1'b1 : row;
                    data_out <= pix_nxt;
                    out_eol  <= (col_nxt == ADDR_BITS'(WIDTH - 1));
                    out_last <= (idx_nxt == ADDR_BITS'(DEPTH - 1));
                end
            end
        end
    end

    assign bus.in_val   = in_val;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.out_eol  = out_eol;
    assign bus.out_last = out_last;
    assign bus.data_out = data_out;
endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer on a 4x3 frame: a per-cycle vector table for the full-rate
// frame, and a scoreboard queue of expected pixels for stall, abort and back-to-back runs.
module tb_pixel_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DB = 8;
    localparam int AB = 10;
    localparam int N  = W * H;

    typedef struct {
        logic [DB-1:0] data;
        logic          eol;
        logic          last;
    } pix_t;

    typedef struct {
        logic          rdy;
        logic          val;
        logic [DB-1:0] data;
        logic          eol;
        logic          last;
        logic          done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_streamer_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    pixel_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [DB-1:0] model [N];
    pix_t          exp_q [$];
    vec_t          vecs [N+2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base);
        for (int i = 0; i < N; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AB'(i);
            bus.wr_data = DB'(base + i);
            model[i]    = DB'(base + i);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic push_frame();
        pix_t p;
        for (int i = 0; i < N; i++) begin
            p.data = model[i];
            p.eol  = ((i % W) == W - 1);
            p.last = (i == N - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // mode 0: ready every cycle; mode 1: ready pattern 1,0,0 repeating.
    // inject_at: transfer count at which a stray start and store write are driven.
    // abort_at: return early once this many transfers have completed.
    task automatic stream(input int mode, input int inject_at, input int abort_at, input int budget);
        int            xfers    = 0;
        int            cyc      = 0;
        logic          stalled  = 1'b0;
        logic          injected = 1'b0;
        logic [DB-1:0] held     = '0;
        logic          rdy;
        while (exp_q.size() > 0) begin
            if (cyc >= budget) begin
                chk("stream_timeout", exp_q.size(), 0);
                return;
            end
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.out_ready = rdy;
            if (xfers == inject_at && !injected) begin
                injected    = 1'b1;
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = AB'(3);
                bus.wr_data = 8'hFF;
            end
            chk("in_val", bus.in_val, 1'b1);
            chk("busy", bus.busy, 1'b1);
            chk("data_out", bus.data_out, exp_q[0].data);
            chk("out_eol", bus.out_eol, exp_q[0].eol);
            chk("out_last", bus.out_last, exp_q[0].last);
            if (stalled)
                chk("stall_hold", bus.data_out, held);
            held    = bus.data_out;
            stalled = !rdy;
            if (rdy && bus.in_val) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            tick();
            cyc++;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (abort_at > 0 && xfers == abort_at)
                return;
        end
        chk("done_pulse", bus.done, 1'b1);
        chk("in_val_end", bus.in_val, 1'b0);
        chk("busy_end", bus.busy, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            vecs[i].rdy  = 1'b1;
            vecs[i].val  = 1'b1;
            vecs[i].data = DB'(10 + i);
            vecs[i].eol  = ((i % W) == W - 1);
            vecs[i].last = (i == N - 1);
            vecs[i].done = 1'b0;
        end
        vecs[N]   = '{rdy: 1'b1, val: 1'b0, data: 8'd21, eol: 1'b0, last: 1'b0, done: 1'b1};
        vecs[N+1] = '{rdy: 1'b1, val: 1'b0, data: 8'd21, eol: 1'b0, last: 1'b0, done: 1'b0};

        #1;
        chk("rst_in_val", bus.in_val, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_eol", bus.out_eol, 1'b0);
        chk("rst_last", bus.out_last, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full-rate frame from the vector table
        load_frame(10);
        start_frame();
        for (int i = 0; i < N + 2; i++) begin
            chk($sformatf("vec%0d_val", i), bus.in_val, vecs[i].val);
            chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].data);
            chk($sformatf("vec%0d_eol", i), bus.out_eol, vecs[i].eol);
            chk($sformatf("vec%0d_last", i), bus.out_last, vecs[i].last);
            chk($sformatf("vec%0d_done", i), bus.done, vecs[i].done);
            bus.out_ready = vecs[i].rdy;
            tick();
        end

        // Stalled frame
        start_frame();
        push_frame();
        stream(1, -1, -1, 100);
        tick();
        chk("done_one_cycle", bus.done, 1'b0);

        // Stray start and store write mid-stream
        start_frame();
        push_frame();
        stream(0, 5, -1, 40);
        tick();
        chk("stray_start_busy", bus.busy, 1'b0);
        chk("stray_start_val", bus.in_val, 1'b0);
        start_frame();
        push_frame();
        stream(0, -1, -1, 40);
        tick();

        // Out-of-range writes in IDLE, then back-to-back frames
        bus.wr_en   = 1'b1;
        bus.wr_addr = AB'(12);
        bus.wr_data = 8'hEE;
        tick();
        bus.wr_addr = AB'(19);
        tick();
        bus.wr_en = 1'b0;
        start_frame();
        push_frame();
        stream(0, -1, -1, 40);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_in_val", bus.in_val, 1'b1);
        chk("b2b_data", bus.data_out, 8'd10);
        push_frame();
        stream(0, -1, -1, 40);
        tick();

        // Reset mid-frame
        start_frame();
        push_frame();
        stream(0, -1, 6, 40);
        rst = 1'b1;
        #1;
        chk("abort_in_val", bus.in_val, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_data", bus.data_out, 8'h00);
        chk("abort_last", bus.out_last, 1'b0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", bus.done, 1'b0);
            chk("abort_idle", bus.in_val, 1'b0);
            tick();
        end
        load_frame(10);
        start_frame();
        push_frame();
        stream(0, -1, -1, 40);
        tick();
        chk("final_done_low", bus.done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
